// File: rtl/word_aligner_pkg.sv
// Shared definitions for the word aligner: FSM state encodings and the default sync word.
package word_aligner_pkg;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] SYNC_DEFAULT = 8'hD3;

endpackage

// File: rtl/word_rotl.sv
// Combinational 8-bit rotate-left by a 3-bit amount, built as three logarithmic stages.
module word_rotl (
    input  logic [7:0] data,
    input  logic [2:0] amt,
    output logic [7:0] rotated
);

    logic [7:0] stage1;
    logic [7:0] stage2;

    assign stage1  = amt[0] ? {data[6:0],   data[7]}     : data;
    assign stage2  = amt[1] ? {stage1[5:0], stage1[7:6]} : stage1;
    assign rotated = amt[2] ? {stage2[3:0], stage2[7:4]} : stage2;

endmodule

// File: rtl/word_aligner.sv
// Byte-alignment recovery: hunts the sync word at all 8 rotations, verifies it, then de-rotates.
// Optional ALIGN_STATS_EN adds sync_err_cnt / relock_cnt statistics outputs.
module word_aligner
    import word_aligner_pkg::*;
#(
    parameter logic [7:0] SYNC      = SYNC_DEFAULT,
    parameter int         FRAME_LEN = 16,
    parameter int         LOCK_CNT  = 3,
    parameter int         MISS_CNT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        locked,
    output logic [2:0]  amt
`ifdef ALIGN_STATS_EN
    ,
    output logic [15:0] sync_err_cnt,
    output logic [7:0]  relock_cnt
`endif
);

    localparam int WW = $clog2(FRAME_LEN) + 1;
    localparam int HW = $clog2(LOCK_CNT) + 1;
    localparam int MW = $clog2(MISS_CNT) + 1;

    logic [1:0]    state_reg, state_next;
    logic [WW-1:0] word_cnt_reg, word_cnt_next, word_cnt_inc;
    logic [HW-1:0] hit_cnt_reg, hit_cnt_next, hit_cnt_inc;
    logic [MW-1:0] miss_cnt_reg, miss_cnt_next, miss_cnt_inc;
    logic [2:0]    amt_reg, amt_next, amt_eff;

    logic [7:0]    match;
    logic          hunt_hit;
    logic [2:0]    hunt_k;
    logic [7:0]    rot_out;
    logic          boundary, sync_ok;
    logic          load, sof_next, lock_loss, err_evt;

    // Eight fixed-amount rotators compare the incoming word against SYNC in parallel.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hunt
            logic [7:0] cand;
            word_rotl u_rotl (
                .data    (in_data),
                .amt     (3'(gi)),
                .rotated (cand)
            );
            assign match[gi] = (cand == SYNC);
        end
    endgenerate

    always_comb begin
        hunt_k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (match[i]) hunt_k = 3'(i);
        end
    end

    assign hunt_hit = |match;

    // In HUNT the freshly found amount is used so a LOCK_CNT==1 lock emits aligned data at once.
    assign amt_eff = (state_reg == ST_HUNT) ? hunt_k : amt_reg;

    word_rotl u_out_rotl (
        .data    (in_data),
        .amt     (amt_eff),
        .rotated (rot_out)
    );

    assign boundary     = (word_cnt_reg == '0);
    assign sync_ok      = (rot_out == SYNC);
    assign word_cnt_inc = (word_cnt_reg == WW'(FRAME_LEN - 1)) ? '0 : word_cnt_reg + 1'b1;
    assign hit_cnt_inc  = hit_cnt_reg + 1'b1;
    assign miss_cnt_inc = miss_cnt_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        hit_cnt_next  = hit_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        amt_next      = amt_reg;
        load          = 1'b0;
        sof_next      = 1'b0;
        lock_loss     = 1'b0;
        err_evt       = 1'b0;
        if (in_valid) begin
            case (state_reg)
                ST_HUNT: begin
                    if (hunt_hit) begin
                        amt_next      = hunt_k;
                        word_cnt_next = WW'(1);
                        hit_cnt_next  = HW'(1);
                        miss_cnt_next = '0;
                        if (LOCK_CNT == 1) begin
                            state_next = ST_LOCKED;
                            load       = 1'b1;
                            sof_next   = 1'b1;
                        end else begin
                            state_next = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    word_cnt_next = word_cnt_inc;
                    if (boundary) begin
                        if (sync_ok) begin
                            hit_cnt_next = hit_cnt_inc;
                            if (hit_cnt_inc == HW'(LOCK_CNT)) begin
                                state_next    = ST_LOCKED;
                                miss_cnt_next = '0;
                                load          = 1'b1;
                                sof_next      = 1'b1;
                            end
                        end else if (hunt_hit) begin
                            // The failing word is immediately reconsidered as a new candidate.
                            state_next    = ST_VERIFY;
                            amt_next      = hunt_k;
                            word_cnt_next = WW'(1);
                            hit_cnt_next  = HW'(1);
                        end else begin
                            state_next    = ST_HUNT;
                            word_cnt_next = '0;
                            hit_cnt_next  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    load          = 1'b1;
                    word_cnt_next = word_cnt_inc;
                    if (boundary) begin
                        sof_next = 1'b1;
                        if (sync_ok) begin
                            miss_cnt_next = '0;
                        end else begin
                            err_evt = 1'b1;
                            if (miss_cnt_inc == MW'(MISS_CNT)) begin
                                state_next    = ST_HUNT;
                                miss_cnt_next = '0;
                                hit_cnt_next  = '0;
                                word_cnt_next = '0;
                                lock_loss     = 1'b1;
                            end else begin
                                miss_cnt_next = miss_cnt_inc;
                            end
                        end
                    end
                end
                default: begin
                    state_next    = ST_HUNT;
                    word_cnt_next = '0;
                    hit_cnt_next  = '0;
                    miss_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_HUNT;
            word_cnt_reg <= '0;
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            amt_reg      <= '0;
            locked       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sof      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            hit_cnt_reg  <= hit_cnt_next;
            miss_cnt_reg <= miss_cnt_next;
            amt_reg      <= amt_next;
            locked       <= (state_next == ST_LOCKED);
            out_valid    <= load;
            out_sof      <= load & sof_next;
            if (load) out_data <= rot_out;
        end
    end

    assign amt = amt_reg;

`ifdef ALIGN_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_err_cnt <= '0;
            relock_cnt   <= '0;
        end else begin
            if (err_evt && (sync_err_cnt != 16'hFFFF)) sync_err_cnt <= sync_err_cnt + 16'd1;
            if (lock_loss && (relock_cnt != 8'hFF)) relock_cnt <= relock_cnt + 8'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = err_evt ^ lock_loss;
`endif

endmodule
